// File: rtl/memoria_resposta.sv
// Memory responder: 2^ADDR_WIDTH x DATA_WIDTH synchronous word memory that
// self-initialises after reset, then serves single-cycle read/write requests.
module memoria_resposta #(
    parameter int                    ADDR_WIDTH = 5,
    parameter int                    DATA_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] INIT_BASE  = '0
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  ReadEnable,
    input  logic                  WriteEnable,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0] DataIN,
    output logic [DATA_WIDTH-1:0] DataOut,
    output logic                  MemReady,
    output logic                  Collision,
    output logic [7:0]            ReadCount,
    output logic [7:0]            WriteCount
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {INIT, SERVE} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] init_idx;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] init_word;
    logic                  serve_wr;

    assign init_word = INIT_BASE + DATA_WIDTH'(init_idx);
    assign serve_wr  = (state == SERVE) && WriteEnable;

    // Array has no reset; gating on Reset keeps word 0 untouched while reset is held.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            if (state == INIT)
                mem[init_idx] <= init_word;
            else if (serve_wr)
                mem[Address] <= DataIN;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state      <= INIT;
            init_idx   <= '0;
            DataOut    <= '0;
            MemReady   <= 1'b0;
            Collision  <= 1'b0;
            ReadCount  <= '0;
            WriteCount <= '0;
        end else begin
            case (state)
                INIT: begin
                    Collision <= 1'b0;
                    init_idx  <= init_idx + ADDR_WIDTH'(1);
                    if (init_idx == '1) begin
                        state    <= SERVE;
                        MemReady <= 1'b1;
                    end
                end
                SERVE: begin
                    Collision <= ReadEnable && WriteEnable;
                    // Write-first on a same-cycle read/write: return the incoming word.
                    if (ReadEnable) begin
                        DataOut <= WriteEnable ? DataIN : mem[Address];
                        if (ReadCount != 8'hFF)
                            ReadCount <= ReadCount + 8'd1;
                    end
                    if (WriteEnable && WriteCount != 8'hFF)
                        WriteCount <= WriteCount + 8'd1;
                end
                default: state <= INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_memoria_resposta.sv
// Self-checking bench for memoria_resposta: table vectors plus init, saturation
// and mid-operation reset sequences, checked through an expectation queue.
module tb_memoria_resposta;
    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        ReadEnable = 1'b0;
    logic        WriteEnable = 1'b0;
    logic [4:0]  Address = '0;
    logic [15:0] DataIN = '0;
    logic [15:0] DataOut;
    logic        MemReady;
    logic        Collision;
    logic [7:0]  ReadCount;
    logic [7:0]  WriteCount;

    memoria_resposta dut (
        .Clock(Clock), .Reset(Reset), .ReadEnable(ReadEnable), .WriteEnable(WriteEnable),
        .Address(Address), .DataIN(DataIN), .DataOut(DataOut), .MemReady(MemReady),
        .Collision(Collision), .ReadCount(ReadCount), .WriteCount(WriteCount)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic        re;
        logic        we;
        logic [4:0]  addr;
        logic [15:0] din;
        logic [15:0] exp_dout;
        logic        exp_coll;
    } vec_t;

    typedef struct {
        logic [15:0] dout;
        logic        coll;
        logic [7:0]  rc;
        logic [7:0]  wc;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] m_mem [32];
    logic [15:0] m_dout;
    logic [7:0]  m_rc, m_wc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = 16'(i);
        m_dout = '0;
        m_rc   = '0;
        m_wc   = '0;
    endtask

    // Drive one SERVE request, push the model's expectation, clock, pop and compare.
    task automatic apply(input logic re, input logic we, input logic [4:0] a, input logic [15:0] d);
        exp_t e;
        ReadEnable  = re;
        WriteEnable = we;
        Address     = a;
        DataIN      = d;
        if (we) m_mem[a] = d;
        if (re) m_dout = m_mem[a];
        if (re && m_rc != 8'hFF) m_rc++;
        if (we && m_wc != 8'hFF) m_wc++;
        e.dout = m_dout;
        e.coll = re && we;
        e.rc   = m_rc;
        e.wc   = m_wc;
        sbq.push_back(e);
        @(posedge Clock);
        #1;
        ReadEnable  = 1'b0;
        WriteEnable = 1'b0;
        e = sbq.pop_front();
        chk("DataOut", 32'(DataOut), 32'(e.dout));
        chk("Collision", 32'(Collision), 32'(e.coll));
        chk("ReadCount", 32'(ReadCount), 32'(e.rc));
        chk("WriteCount", 32'(WriteCount), 32'(e.wc));
    endtask

    // Assert reset, check reset values, release and step through the 32 init edges.
    task automatic reset_and_init(input bit poke_init);
        ReadEnable  = 1'b0;
        WriteEnable = 1'b0;
        Reset = 1'b0;
        #1;
        chk("rst_DataOut", 32'(DataOut), 32'd0);
        chk("rst_MemReady", 32'(MemReady), 32'd0);
        chk("rst_Collision", 32'(Collision), 32'd0);
        chk("rst_ReadCount", 32'(ReadCount), 32'd0);
        chk("rst_WriteCount", 32'(WriteCount), 32'd0);
        model_reset();
        @(negedge Clock);
        Reset = 1'b1;
        for (int e = 1; e <= 32; e++) begin
            @(posedge Clock);
            #1;
            chk($sformatf("init_MemReady_e%0d", e), 32'(MemReady), 32'(e == 32));
            if (e < 32) begin
                chk("init_DataOut", 32'(DataOut), 32'd0);
                chk("init_Collision", 32'(Collision), 32'd0);
            end
            // Request presented so it is sampled at edge 10; must be dropped.
            if (poke_init && e == 9) begin
                ReadEnable  = 1'b1;
                WriteEnable = 1'b1;
                Address     = 5'd2;
                DataIN      = 16'hAAAA;
            end
            if (e == 10) begin
                ReadEnable  = 1'b0;
                WriteEnable = 1'b0;
            end
        end
        chk("init_WriteCount", 32'(WriteCount), 32'd0);
        chk("init_ReadCount", 32'(ReadCount), 32'd0);
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{1'b1, 1'b0, 5'd0,  16'h0000, 16'h0000, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 5'd5,  16'h0000, 16'h0005, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 5'd31, 16'h0000, 16'h001F, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 5'd2,  16'h0000, 16'h0002, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 5'd7,  16'hBEEF, 16'h0002, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 5'd7,  16'h0000, 16'hBEEF, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 5'd3,  16'h1234, 16'h1234, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 5'd3,  16'h0000, 16'h1234, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 5'd3,  16'h0000, 16'h1234, 1'b0};
        vecs[9] = '{1'b1, 1'b0, 5'd4,  16'h0000, 16'h0004, 1'b0};

        #2;
        reset_and_init(1'b1);

        for (int i = 0; i < 10; i++) begin
            apply(vecs[i].re, vecs[i].we, vecs[i].addr, vecs[i].din);
            chk($sformatf("vec%0d_DataOut", i), 32'(DataOut), 32'(vecs[i].exp_dout));
            chk($sformatf("vec%0d_Collision", i), 32'(Collision), 32'(vecs[i].exp_coll));
            if (i == 2) chk("three_reads_ReadCount", 32'(ReadCount), 32'd3);
        end
        chk("tbl_WriteCount", 32'(WriteCount), 32'd2);

        // Long read burst drives ReadCount into saturation.
        for (int i = 0; i < 300; i++) apply(1'b1, 1'b0, 5'(i), 16'h0000);
        chk("sat_ReadCount", 32'(ReadCount), 32'd255);
        apply(1'b1, 1'b0, 5'd7, 16'h0000);
        chk("sat_hold_ReadCount", 32'(ReadCount), 32'd255);
        chk("sat_DataOut", 32'(DataOut), 32'hBEEF);

        // Write then reset mid-SERVE: the write must be lost after re-init.
        apply(1'b0, 1'b1, 5'd4, 16'h5555);
        apply(1'b1, 1'b0, 5'd4, 16'h0000);
        chk("pre_rst_DataOut", 32'(DataOut), 32'h5555);
        reset_and_init(1'b0);
        apply(1'b1, 1'b0, 5'd4, 16'h0000);
        chk("post_rst_DataOut", 32'(DataOut), 32'h0004);
        chk("post_rst_ReadCount", 32'(ReadCount), 32'd1);
        apply(1'b0, 1'b0, 5'd0, 16'h0000);
        chk("idle_hold_DataOut", 32'(DataOut), 32'h0004);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/memoria_resposta.md
# memoria_resposta

Memory responder for the accumulator datapath: a 32×16 synchronous word memory that answers the ReadEnable/WriteEnable/Address/DataIN requests issued by the controller and returns read data on DataOut. After every reset it runs a self-initialisation pass that fills all words with a known pattern. It signals readiness, flags simultaneous read/write, and keeps saturating access counters for debug. It sits between the FSM/accumulator top level and the rest of the system.

## Interface

Parameters:
- ADDR_WIDTH, 5: address width; depth = 2^ADDR_WIDTH = 32 words.
- DATA_WIDTH, 16: word width.
- INIT_BASE, 16'h0000: init pattern base; word i is loaded with INIT_BASE + i, truncated to DATA_WIDTH.

Ports:
- Clock  in  1  single clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- ReadEnable  in  1  read request for Address, sampled on the rising edge.
- WriteEnable  in  1  write request of DataIN to Address, sampled on the rising edge.
- Address  in  ADDR_WIDTH  word address.
- DataIN  in  DATA_WIDTH  write data from the requester.
- DataOut  out  DATA_WIDTH  registered read data.
- MemReady  out  1  high when the memory accepts requests.
- Collision  out  1  one-cycle pulse when ReadEnable and WriteEnable are both sampled high in SERVE.
- ReadCount  out  8  accepted reads, saturating at 255.
- WriteCount  out  8  accepted writes, saturating at 255.

## Operation

- Two states: INIT and SERVE.
- Reset low, asynchronous:
  - State forced to INIT and init index set to 0.
  - Outputs: DataOut=0, MemReady=0, Collision=0, ReadCount=0, WriteCount=0.
  - Array contents are not cleared by reset itself; INIT overwrites them.
- INIT: each edge writes mem[index] <= INIT_BASE + index and increments index. The edge that writes index 31 moves to SERVE and sets MemReady=1.
- During INIT, ReadEnable and WriteEnable are ignored:
  - no array write, DataOut holds 0, counters unchanged, Collision stays 0.
- SERVE, read only: DataOut <= mem[Address]; ReadCount += 1 (saturating).
- SERVE, write only: mem[Address] <= DataIN; WriteCount += 1 (saturating).
- SERVE, read and write in the same cycle:
  - Write-first: the array is updated and DataOut <= DataIN (new data).
  - Both counters increment.
  - Collision=1 for exactly that following cycle.
- SERVE, no request: DataOut holds its last value; Collision=0.
- Counters saturate: a counter at 255 stays at 255; there is no wrap-around.
- Address is always in range because it is ADDR_WIDTH bits; there is no out-of-range case.
- Reset asserted mid-operation (in INIT or SERVE): immediate return to the reset values above, then a full re-initialisation. Writes made before the reset are lost.

## Timing

- INIT takes exactly 32 rising edges after Reset deasserts. MemReady is 1 after the 32nd edge.
- Requesters must hold requests until MemReady=1. Requests presented earlier are dropped silently.
- Read latency is 1 cycle: ReadEnable sampled at edge N gives valid DataOut after edge N, usable before edge N+1.
- Write latency is 1 cycle: a read of the same address sampled at edge N+1 or later returns the written data.
- Back-to-back requests are accepted every cycle; there are no wait states and no busy signal in SERVE.
- Collision, MemReady, DataOut and the counters are all registered outputs with no combinational paths from inputs.

## Test plan

- Reset release, no requests -> MemReady stays 0 for 31 edges and goes 1 after edge 32. Reading addresses 0, 5 and 31 then returns 16'h0000, 16'h0005 and 16'h001F. ReadCount=3.
- Write 16'hBEEF to address 7, then read 7 on the next cycle -> DataOut=16'hBEEF one cycle after the read. WriteCount=1, ReadCount=1.
- Same-cycle ReadEnable=1, WriteEnable=1, Address=3, DataIN=16'h1234 -> DataOut=16'h1234 and Collision=1 for one cycle. Both counters +1. A later read of 3 returns 16'h1234.
- Request during INIT (write 16'hAAAA to address 2 at edge 10) -> ignored. After MemReady, a read of 2 returns 16'h0002 and WriteCount=0.
- 300 consecutive reads -> ReadCount stops at 255 and does not wrap; DataOut stays correct throughout.
- Write 16'h5555 to address 4, then assert Reset mid-SERVE -> all outputs 0 immediately, INIT reruns for 32 edges, and a read of 4 returns 16'h0004.
